ahb_sram_slave: RTL and testbench
=================================

Name: ahb_sram_slave

Overview:
AHB-Lite slave that responds to the CPU core's bus requests and serves instruction and data memory from an internal word array. It decodes the address phase and runs a pipelined data phase with configurable wait states. It returns read data on HRDATA, or commits byte/half/word writes. Illegal accesses get the two-cycle AHB ERROR response.

Parameters:
DEPTH, 1024, number of 32-bit words in the array; addressable range is 0 to DEPTH*4-1
WAIT_STATES, 0, data-phase cycles with HREADYOUT low before completion (0..15)

Ports:
clock  input  1  system clock, rising edge
nRst  input  1  asynchronous active-low reset
HSEL  input  1  slave select from the address decoder
HADDR  input  32  byte address, address phase
HTRANS  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
HWRITE  input  1  1=write, 0=read, address phase
HSIZE  input  3  0=byte, 1=half, 2=word; values above 2 are illegal
HWDATA  input  32  write data, data phase
HREADY  input  1  bus-wide ready; a transfer is sampled only when it is high
HREADYOUT  output  1  slave ready, drives the bus HREADY through the mux
HRESP  output  1  0=OKAY, 1=ERROR
HRDATA  output  32  read data, valid when HREADYOUT=1 in a read data phase

Behaviour:
- Reset (async, nRst=0): HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, latched control cleared. Array contents are not reset.
- Reset asserted mid-transfer aborts the pending data phase. No array write occurs.
- Address-phase accept condition: HSEL && HREADY && HTRANS[1].
  - On accept, latch addr, write, size, and an error flag.
  - IDLE or BUSY transfers, or HSEL=0, get a zero-wait OKAY (HREADYOUT=1, HRESP=0) and have no side effect.
- Error flag is set if any of these hold: addr >= DEPTH*4; HSIZE>2; half access with addr[0]=1; word access with addr[1:0]!=0.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: on an accepted legal transfer, go to WAIT if WAIT_STATES>0; otherwise complete in the next cycle with HREADYOUT=1. On an accepted errored transfer, go to ERR1.
  - WAIT: HREADYOUT=0 for exactly WAIT_STATES cycles, counted by a 4-bit down-counter. Then one completion cycle with HREADYOUT=1, HRESP=0.
  - ERR1: HREADYOUT=0, HRESP=1, one cycle.
  - ERR2: HREADYOUT=1, HRESP=1, one cycle. A new accepted transfer during ERR2 is honoured normally.
  - A completion cycle (HREADYOUT=1) may accept the next address phase. Back-to-back transfers therefore pipeline with no bubble.
- Write commit: on the completion cycle's rising edge. HWDATA is sampled in that cycle; only the byte lanes selected by size/addr[1:0] are written.
  - Lanes are little-endian: byte at addr[1:0]=n occupies bits 8n+7:8n; half at addr[1]=h occupies bits 16h+15:16h.
- Errored transfers never write.
- Read: asynchronous array read at latched word index addr[31:2]. The full 32-bit word is driven on HRDATA during the completion cycle; the master extracts lanes.
  - HRDATA=0 in every other cycle, including the ERR states.
- Read directly after a write to the same word (zero-wait, back-to-back) returns the newly written data, because the write commits before the read's data phase.
- Word index width is $clog2(DEPTH). Upper address bits only feed the range check.

Decomposition:
- Shared package ahb_pkg:
  - htrans_t enum (IDLE, BUSY, NONSEQ, SEQ)
  - hsize_t constants (BYTE, HALF, WORD)
  - HRESP_OKAY and HRESP_ERROR constants
  - slave_state_t enum
  - The CPU master uses the same package.
- One sub-module, sram_array:
  - Parameter DEPTH.
  - Inputs: clock, 4-bit byte write-enable, word index, write data.
  - Asynchronous read port.
  - No reset.

Test Plan:
- Word write NONSEQ HADDR=0x10, HWDATA=0xDEADBEEF, then read 0x10 back-to-back with WAIT_STATES=0 -> second data phase HRDATA=0xDEADBEEF, HREADYOUT=1 every cycle, HRESP=0.
- Byte write 0xAA to 0x13 over word 0x11223344 at 0x10, then word read 0x10 -> 0xAA223344.
- WAIT_STATES=3, read 0x10 -> HREADYOUT low for exactly 3 cycles, then high with data; HRDATA=0 while low.
- Read HADDR=DEPTH*4 (0x1000) -> ERR1 (HREADYOUT=0, HRESP=1), ERR2 (HREADYOUT=1, HRESP=1), then OKAY. Misaligned word write to 0x12 -> same two-cycle ERROR, and word 0x10 is unchanged.
- HTRANS=IDLE or BUSY with HSEL=1, and NONSEQ with HSEL=0 -> HREADYOUT=1, HRESP=0, no array change.
- nRst pulsed low during the WAIT of a write to 0x20 (WAIT_STATES=2) -> outputs return to reset values immediately; a later read of 0x20 returns the old value.

Source files
------------

// File: rtl/ahb_pkg.sv
// AHB-Lite types and constants shared by the SRAM slave and the CPU master.
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'd0,
      HTRANS_BUSY   = 2'd1,
      HTRANS_NONSEQ = 2'd2,
      HTRANS_SEQ    = 2'd3
   } htrans_t;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ERR1,
      ST_ERR2
   } slave_state_t;

   // Little-endian byte lanes touched by an aligned access of the given size.
   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
      logic [3:0] m;
      case ({1'b0, size})
         HSIZE_BYTE: m = 4'b0001 << lo;
         HSIZE_HALF: m = lo[1] ? 4'b1100 : 4'b0011;
         default:    m = 4'b1111;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/sram_array.sv
// Word array split into four byte-lane memories; byte-enable write, asynchronous read.
module sram_array #(
   parameter int DEPTH = 1024,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clock,
   input  logic [3:0]    be,
   input  logic [AW-1:0] idx,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];

      always_ff @(posedge clock) begin
         if (be[gi]) begin
            mem[idx] <= wdata[8*gi +: 8];
         end
      end

      assign rdata[8*gi +: 8] = mem[idx];
   end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: pipelined data phase, configurable wait states,
// two-cycle ERROR response for out-of-range, oversized or misaligned accesses.
module ahb_sram_slave
   import ahb_pkg::*;
#(
   parameter int DEPTH       = 1024,
   parameter int WAIT_STATES = 0
) (
   input  logic        clock,
   input  logic        nRst,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic        HREADYOUT,
   output logic        HRESP,
   output logic [31:0] HRDATA
);

   localparam int          AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [32:0] LIMIT = 33'(DEPTH) << 2;
   localparam logic [3:0]  WS    = 4'(WAIT_STATES);

   slave_state_t  state_reg;
   logic          pending_reg;
   logic          write_reg;
   logic [1:0]    size_reg;
   logic [1:0]    lo_reg;
   logic [AW-1:0] idx_reg;
   logic [3:0]    cnt_reg;
   logic          ready_reg;
   logic          resp_reg;

   htrans_t       trans;
   logic          accept;
   logic          addr_err;
   logic [3:0]    be;
   logic [31:0]   rdata;

   assign trans  = htrans_t'(HTRANS);
   assign accept = HSEL && HREADY && (trans == HTRANS_NONSEQ || trans == HTRANS_SEQ);

   // Upper address bits only matter for the range check.
   assign addr_err = ({1'b0, HADDR} >= LIMIT)
                  || (HSIZE > HSIZE_WORD)
                  || (HSIZE == HSIZE_HALF && HADDR[0])
                  || (HSIZE == HSIZE_WORD && HADDR[1:0] != 2'b00);

   always_ff @(posedge clock or negedge nRst) begin
      if (!nRst) begin
         state_reg   <= ST_IDLE;
         pending_reg <= 1'b0;
         write_reg   <= 1'b0;
         size_reg    <= 2'd0;
         lo_reg      <= 2'd0;
         idx_reg     <= '0;
         cnt_reg     <= 4'd0;
         ready_reg   <= 1'b1;
         resp_reg    <= HRESP_OKAY;
      end else begin
         pending_reg <= 1'b0;
         ready_reg   <= 1'b1;
         resp_reg    <= HRESP_OKAY;
         case (state_reg)
            ST_WAIT: begin
               if (cnt_reg == 4'd1) begin
                  state_reg   <= ST_IDLE;
                  pending_reg <= 1'b1;
               end else begin
                  cnt_reg   <= cnt_reg - 4'd1;
                  ready_reg <= 1'b0;
               end
            end
            ST_ERR1: begin
               state_reg <= ST_ERR2;
               resp_reg  <= HRESP_ERROR;
            end
            default: begin
               // IDLE (possibly a completion cycle) and ERR2 both present HREADYOUT=1.
               state_reg <= ST_IDLE;
               if (accept) begin
                  write_reg <= HWRITE;
                  size_reg  <= HSIZE[1:0];
                  lo_reg    <= HADDR[1:0];
                  idx_reg   <= HADDR[AW+1:2];
                  if (addr_err) begin
                     state_reg <= ST_ERR1;
                     ready_reg <= 1'b0;
                     resp_reg  <= HRESP_ERROR;
                  end else if (WS == 4'd0) begin
                     pending_reg <= 1'b1;
                  end else begin
                     state_reg <= ST_WAIT;
                     cnt_reg   <= WS;
                     ready_reg <= 1'b0;
                  end
               end
            end
         endcase
      end
   end

   // pending_reg marks the completion cycle; a write commits on its closing edge.
   assign be = (pending_reg && write_reg) ? lane_mask(size_reg, lo_reg) : 4'b0000;

   sram_array #(
      .DEPTH(DEPTH)
   ) u_sram_array (
      .clock(clock),
      .be   (be),
      .idx  (idx_reg),
      .wdata(HWDATA),
      .rdata(rdata)
   );

   assign HREADYOUT = ready_reg;
   assign HRESP     = resp_reg;
   assign HRDATA    = (pending_reg && !write_reg) ? rdata : 32'd0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: three instances (0, 3, 2 wait states) on one shared bus,
// table vectors, hand-written pipeline/idle/reset sequences and a random run vs a byte model.
module tb_ahb_sram_slave;

   logic        clock = 1'b0;
   logic        n_rst = 1'b1;
   logic [2:0]  hsel  = 3'b000;
   logic [31:0] haddr = 32'd0;
   logic [1:0]  htrans = 2'd0;
   logic        hwrite = 1'b0;
   logic [2:0]  hsize = 3'd0;
   logic [31:0] hwdata = 32'd0;
   logic        hready;
   logic [2:0]  ready_v;
   logic [2:0]  resp_v;
   logic [31:0] rdata [3];
   int          cur = 0;
   int          ws [3] = '{0, 3, 2};

   int total = 0;
   int bad   = 0;

   logic [7:0] rb [3][4096];
   bit         kn [3][4096];

   always #5 clock = ~clock;
   assign hready = ready_v[cur];

   ahb_sram_slave #(.DEPTH(1024), .WAIT_STATES(0)) dut0 (
      .clock(clock), .nRst(n_rst), .HSEL(hsel[0]), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
      .HREADYOUT(ready_v[0]), .HRESP(resp_v[0]), .HRDATA(rdata[0]));
   ahb_sram_slave #(.DEPTH(1024), .WAIT_STATES(3)) dut1 (
      .clock(clock), .nRst(n_rst), .HSEL(hsel[1]), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
      .HREADYOUT(ready_v[1]), .HRESP(resp_v[1]), .HRDATA(rdata[1]));
   ahb_sram_slave #(.DEPTH(1024), .WAIT_STATES(2)) dut2 (
      .clock(clock), .nRst(n_rst), .HSEL(hsel[2]), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
      .HREADYOUT(ready_v[2]), .HRESP(resp_v[2]), .HRDATA(rdata[2]));

   typedef struct {
      string       nm;
      int          d;
      logic [31:0] a;
      logic        w;
      logic [2:0]  sz;
      logic [31:0] wd;
      logic        e_err;
      logic [31:0] e_rd;
   } vec_t;

   task automatic chk(input string nm, input int d, input logic r_exp, input logic p_exp,
                      input logic [31:0] d_exp, input logic [31:0] m);
      total++;
      if (ready_v[d] !== r_exp || resp_v[d] !== p_exp || (rdata[d] & m) !== (d_exp & m)) begin
         bad++;
         $display("FAIL %s dut%0d: got ready=%b resp=%b rdata=%h, expected ready=%b resp=%b rdata=%h (mask %h)",
                  nm, d, ready_v[d], resp_v[d], rdata[d], r_exp, p_exp, d_exp, m);
      end
   endtask

   // Reference rules: in range, size <= word, naturally aligned.
   function automatic bit m_err(input logic [31:0] a, input logic [2:0] sz);
      if (a >= 32'h1000 || sz > 3'd2) return 1'b1;
      return (a % (32'd1 << sz)) != 32'd0;
   endfunction

   task automatic m_write(input int d, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
      int n;
      int b;
      n = 1 << sz;
      for (int k = 0; k < n; k++) begin
         b = int'(a) + k;
         rb[d][b] = wd[8*(b%4) +: 8];
         kn[d][b] = 1'b1;
      end
   endtask

   task automatic m_read(input int d, input logic [31:0] a, output logic [31:0] e, output logic [31:0] m);
      int base;
      base = int'(a) - int'(a % 4);
      e = 32'd0;
      m = 32'd0;
      for (int k = 0; k < 4; k++) begin
         if (kn[d][base+k]) begin
            e[8*k +: 8] = rb[d][base+k];
            m[8*k +: 8] = 8'hFF;
         end
      end
   endtask

   // One isolated transfer: address phase, full data phase profile, one trailing idle cycle.
   task automatic xfer(input string nm, input int d, input logic [1:0] tr, input logic [31:0] a,
                       input logic w, input logic [2:0] sz, input logic [31:0] wd,
                       input logic e_err, input logic [31:0] e_rd, input logic [31:0] m);
      @(posedge clock); #1;
      cur = d; hsel = 3'(1 << d); haddr = a; htrans = tr; hwrite = w; hsize = sz;
      @(posedge clock); #1;
      hsel = 3'b000; htrans = 2'd0; haddr = $urandom; hwdata = wd;
      if (e_err) begin
         @(negedge clock); chk({nm, "_err1"}, d, 1'b0, 1'b1, 32'd0, '1);
         @(negedge clock); chk({nm, "_err2"}, d, 1'b1, 1'b1, 32'd0, '1);
      end else begin
         for (int c = 0; c < ws[d]; c++) begin
            @(negedge clock); chk({nm, "_wait"}, d, 1'b0, 1'b0, 32'd0, '1);
         end
         @(negedge clock);
         if (w) chk({nm, "_done"}, d, 1'b1, 1'b0, 32'd0, '1);
         else   chk({nm, "_done"}, d, 1'b1, 1'b0, e_rd, m);
      end
      @(negedge clock); chk({nm, "_idle"}, d, 1'b1, 1'b0, 32'd0, '1);
      $display("xfer %s dut%0d addr=%h w=%b size=%0d wdata=%h", nm, d, a, w, sz, wd);
   endtask

   // Address phase that must be ignored (IDLE/BUSY, or not selected).
   task automatic no_xfer(input string nm, input int d, input logic [1:0] tr, input bit sel);
      @(posedge clock); #1;
      cur = d; hsel = sel ? 3'(1 << d) : 3'b000; haddr = 32'h10; htrans = tr; hwrite = 1'b1; hsize = 3'd2;
      @(negedge clock); chk({nm, "_addr"}, d, 1'b1, 1'b0, 32'd0, '1);
      @(posedge clock); #1;
      hsel = 3'b000; htrans = 2'd0; hwdata = 32'h0BAD_0BAD;
      @(negedge clock); chk({nm, "_data"}, d, 1'b1, 1'b0, 32'd0, '1);
      $display("xfer %s dut%0d ignored htrans=%0d hsel=%b", nm, d, tr, sel);
   endtask

   vec_t vecs [$];

   initial begin
      logic [31:0] e;
      logic [31:0] m;

      vecs.push_back('{"w_word",      0, 32'h10,       1'b1, 3'd2, 32'h1122_3344, 1'b0, 32'h0});
      vecs.push_back('{"w_byte3",     0, 32'h13,       1'b1, 3'd0, 32'hAA55_66FF, 1'b0, 32'h0});
      vecs.push_back('{"r_merge",     0, 32'h10,       1'b0, 3'd2, 32'h0,         1'b0, 32'hAA22_3344});
      vecs.push_back('{"r_oob",       0, 32'h1000,     1'b0, 3'd2, 32'h0,         1'b1, 32'h0});
      vecs.push_back('{"w_misalign",  0, 32'h12,       1'b1, 3'd2, 32'hFFFF_FFFF, 1'b1, 32'h0});
      vecs.push_back('{"r_unchanged", 0, 32'h10,       1'b0, 3'd2, 32'h0,         1'b0, 32'hAA22_3344});
      vecs.push_back('{"w_word14",    0, 32'h14,       1'b1, 3'd2, 32'h0,         1'b0, 32'h0});
      vecs.push_back('{"w_half_hi",   0, 32'h16,       1'b1, 3'd1, 32'h1234_ABCD, 1'b0, 32'h0});
      vecs.push_back('{"w_half_odd",  0, 32'h15,       1'b1, 3'd1, 32'hFFFF_FFFF, 1'b1, 32'h0});
      vecs.push_back('{"w_size3",     0, 32'h14,       1'b1, 3'd3, 32'hFFFF_FFFF, 1'b1, 32'h0});
      vecs.push_back('{"r_half_hi",   0, 32'h14,       1'b0, 3'd2, 32'h0,         1'b0, 32'h1234_0000});
      vecs.push_back('{"w_byte1",     0, 32'h15,       1'b1, 3'd0, 32'h9988_7766, 1'b0, 32'h0});
      vecs.push_back('{"r_byte1",     0, 32'h14,       1'b0, 3'd2, 32'h0,         1'b0, 32'h1234_7700});
      vecs.push_back('{"w_ws3",       1, 32'h10,       1'b1, 3'd2, 32'hCAFE_F00D, 1'b0, 32'h0});
      vecs.push_back('{"r_ws3",       1, 32'h10,       1'b0, 3'd2, 32'h0,         1'b0, 32'hCAFE_F00D});
      vecs.push_back('{"r_ws3_oob",   1, 32'hFFFF_FFFC, 1'b0, 3'd2, 32'h0,        1'b1, 32'h0});
      vecs.push_back('{"w_ws2",       2, 32'h20,       1'b1, 3'd2, 32'h0102_0304, 1'b0, 32'h0});
      vecs.push_back('{"r_ws2",       2, 32'h20,       1'b0, 3'd2, 32'h0,         1'b0, 32'h0102_0304});

      // Reset state
      #3 n_rst = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      for (int d = 0; d < 3; d++) chk("reset", d, 1'b1, 1'b0, 32'd0, '1);
      n_rst = 1'b1;

      // Back-to-back write then read of the same word, zero wait states
      @(posedge clock); #1;
      cur = 0; hsel = 3'b001; haddr = 32'h10; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2;
      @(posedge clock); #1;
      hwrite = 1'b0; hwdata = 32'hDEAD_BEEF;
      @(negedge clock); chk("b2b_wr", 0, 1'b1, 1'b0, 32'd0, '1);
      @(posedge clock); #1;
      hsel = 3'b000; htrans = 2'd0;
      @(negedge clock); chk("b2b_rd", 0, 1'b1, 1'b0, 32'hDEAD_BEEF, '1);
      m_write(0, 32'h10, 3'd2, 32'hDEAD_BEEF);
      $display("xfer b2b dut0 write+read addr=00000010");

      // Table vectors
      foreach (vecs[i]) begin
         xfer(vecs[i].nm, vecs[i].d, 2'd2, vecs[i].a, vecs[i].w, vecs[i].sz, vecs[i].wd,
              vecs[i].e_err, vecs[i].e_rd, '1);
         if (vecs[i].w && !vecs[i].e_err) m_write(vecs[i].d, vecs[i].a, vecs[i].sz, vecs[i].wd);
      end

      // Ignored transfers leave word 0x10 alone
      no_xfer("idle_sel", 0, 2'd0, 1'b1);
      no_xfer("busy_sel", 0, 2'd1, 1'b1);
      no_xfer("nonseq_nosel", 0, 2'd2, 1'b0);
      xfer("r_after_ignored", 0, 2'd2, 32'h10, 1'b0, 3'd2, 32'h0, 1'b0, 32'hAA22_3344, '1);

      // Reset during the wait states of a write aborts it
      @(posedge clock); #1;
      cur = 2; hsel = 3'b100; haddr = 32'h20; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2;
      @(posedge clock); #1;
      hsel = 3'b000; htrans = 2'd0; hwdata = 32'hFFFF_FFFF;
      @(negedge clock); chk("rst_pre", 2, 1'b0, 1'b0, 32'd0, '1);
      #2 n_rst = 1'b0;
      #1 chk("rst_async", 2, 1'b1, 1'b0, 32'd0, '1);
      @(posedge clock);
      @(negedge clock); n_rst = 1'b1;
      $display("xfer rst_abort dut2 addr=00000020");
      xfer("r_after_rst", 2, 2'd2, 32'h20, 1'b0, 3'd2, 32'h0, 1'b0, 32'h0102_0304, '1);

      // Random transfers against the byte-level model
      for (int t = 0; t < 200; t++) begin
         int          d;
         logic [31:0] a;
         logic [2:0]  sz;
         logic        w;
         logic [31:0] wd;
         logic [1:0]  tr;
         bit          er;
         d  = $urandom_range(0, 2);
         sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
         if ($urandom_range(0, 9) == 0) a = 32'h1000 + ($urandom & 32'h7FFF_FFFF);
         else                           a = 32'($urandom_range(0, 63));
         if (sz <= 3'd2 && $urandom_range(0, 3) != 0) a = a - (a % (32'd1 << sz));
         w  = 1'($urandom_range(0, 1));
         wd = $urandom;
         tr = $urandom_range(0, 1) ? 2'd2 : 2'd3;
         er = m_err(a, sz);
         e  = 32'd0;
         m  = 32'd0;
         if (!er && !w) m_read(d, a, e, m);
         xfer("rand", d, tr, a, w, sz, wd, er, e, m);
         if (!er && w) m_write(d, a, sz, wd);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
